// File: rtl/sample_pkg.sv
// Shared types and defaults for the sample-latch / debounce datapath.
package sample_pkg;

    localparam int unsigned WidthDefault = 4;

    typedef enum logic {
        StStable   = 1'b0,
        StSettling = 1'b1
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_debounce.sv
// Debounces a sampled word: a new value is accepted only after STABLE_CYCLES equal samples.
module sample_debounce
    import sample_pkg::*;
#(
    parameter int unsigned WIDTH         = WidthDefault,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             chg,
    output logic             busy,
    output logic [7:0]       chg_cnt
);

    localparam int unsigned   CntW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    state_e           state_q;
    logic [WIDTH-1:0] cand_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             chg_q;
    logic             busy_q;
    logic [7:0]       chg_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StStable;
            cand_q    <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            chg_q     <= 1'b0;
            busy_q    <= 1'b0;
            chg_cnt_q <= 8'h00;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                StStable: begin
                    if (din != dout_q) begin
                        cand_q  <= din;
                        cnt_q   <= CntOne;
                        state_q <= StSettling;
                        busy_q  <= 1'b1;
                    end
                end
                StSettling: begin
                    if (din == cand_q) begin
                        if (cnt_q == CntLast) begin
                            dout_q    <= cand_q;
                            chg_q     <= 1'b1;
                            chg_cnt_q <= sat_inc8(chg_cnt_q);
                            cnt_q     <= '0;
                            state_q   <= StStable;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end else if (din == dout_q) begin
                        // Glitch fell back to the accepted value: abandon the candidate.
                        cnt_q   <= '0;
                        state_q <= StStable;
                        busy_q  <= 1'b0;
                    end else begin
                        // The new sample counts as the first of the restarted run.
                        cand_q <= din;
                        cnt_q  <= CntOne;
                    end
                end
                default: begin
                    state_q <= StStable;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout    = dout_q;
    assign chg     = chg_q;
    assign busy    = busy_q;
    assign chg_cnt = chg_cnt_q;

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntLast);
    a_chg_single: assert property (@(posedge clk) disable iff (!rst_n) chg_q |=> !chg_q);
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q == StSettling));
`endif

endmodule

// File: tb/tb_sample_debounce.sv
// Directed bench for sample_debounce with default parameters and a 20 ns clock.
module tb_sample_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] dout;
    logic       chg;
    logic       busy;
    logic [7:0] chg_cnt;

    int checks;
    int errors;

    sample_debounce dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .dout    (dout),
        .chg     (chg),
        .busy    (busy),
        .chg_cnt (chg_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            #5;
            checks++;
            if (dout !== 4'b0000 || busy !== 1'b0 || chg_cnt !== 8'h00 || chg !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: dout=%b busy=%b chg=%b chg_cnt=%h, want 0/0/0/00",
                         i, dout, busy, chg, chg_cnt);
            end
            #5;
        end
        // t = 20 ns: release on the falling edge
        rst_n = 1'b1;
    endtask

    task automatic test_basic_accept();
        step();
        checks++;
        if (busy !== 1'b1 || dout !== 4'b0000) begin
            errors++;
            $display("FAIL accept_edge1: busy=%b dout=%b, want 1/0000", busy, dout);
        end
        for (int e = 2; e <= 3; e++) begin
            step();
            checks++;
            if (dout !== 4'b0000 || chg !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL accept_edge%0d: dout=%b chg=%b busy=%b, want 0000/0/1",
                         e, dout, chg, busy);
            end
        end
        step();
        checks++;
        if (dout !== 4'b0101 || chg !== 1'b1 || chg_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_edge4: dout=%b chg=%b chg_cnt=%0d busy=%b, want 0101/1/1/0",
                     dout, chg, chg_cnt, busy);
        end
        step();
        checks++;
        if (chg !== 1'b0 || dout !== 4'b0101 || chg_cnt !== 8'd1) begin
            errors++;
            $display("FAIL accept_after: chg=%b dout=%b chg_cnt=%0d, want 0/0101/1",
                     chg, dout, chg_cnt);
        end
    endtask

    task automatic test_glitch();
        din = 4'b1010;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || dout !== 4'b0101) begin
            errors++;
            $display("FAIL glitch_settling: busy=%b dout=%b, want 1/0101", busy, dout);
        end
        din = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || dout !== 4'b0101 || chg !== 1'b0 || chg_cnt !== 8'd1) begin
                errors++;
                $display("FAIL glitch_reject[%0d]: busy=%b dout=%b chg=%b chg_cnt=%0d, want 0/0101/0/1",
                         i, busy, dout, chg, chg_cnt);
            end
        end
    endtask

    task automatic test_restart();
        din = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dout !== 4'b0101 || chg !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_pre[%0d]: dout=%b chg=%b busy=%b, want 0101/0/1",
                         i, dout, chg, busy);
            end
        end
        din = 4'b1111;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (dout !== 4'b0101 || chg !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_edge%0d: dout=%b chg=%b busy=%b, want 0101/0/1",
                         e, dout, chg, busy);
            end
        end
        step();
        checks++;
        if (dout !== 4'b1111 || chg !== 1'b1 || chg_cnt !== 8'd2) begin
            errors++;
            $display("FAIL restart_edge4: dout=%b chg=%b chg_cnt=%0d, want 1111/1/2",
                     dout, chg, chg_cnt);
        end
    endtask

    task automatic test_reset_mid_settle();
        din = 4'b1010;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || dout !== 4'b1111) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b dout=%b, want 1/1111", busy, dout);
        end
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 4'b0000 || chg_cnt !== 8'h00 || busy !== 1'b0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: dout=%b chg_cnt=%h busy=%b chg=%b, want 0000/00/0/0",
                     dout, chg_cnt, busy, chg);
        end
        #4;
        rst_n = 1'b1;
        // din still 1010: settles as a fresh change from 0
        step();
        checks++;
        if (busy !== 1'b1 || dout !== 4'b0000 || chg !== 1'b0) begin
            errors++;
            $display("FAIL midrst_restart: busy=%b dout=%b chg=%b, want 1/0000/0", busy, dout, chg);
        end
        step();
        step();
        checks++;
        if (dout !== 4'b0000 || chg !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge3: dout=%b chg=%b, want 0000/0", dout, chg);
        end
        step();
        checks++;
        if (dout !== 4'b1010 || chg !== 1'b1 || chg_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midrst_accept: dout=%b chg=%b chg_cnt=%0d, want 1010/1/1",
                     dout, chg, chg_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] val;
        int         exp_cnt;
        exp_cnt = 1;
        for (int i = 0; i < 260; i++) begin
            val = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            din = val;
            step();
            checks++;
            if (chg !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sat_start[%0d]: chg=%b busy=%b, want 0/1", i, chg, busy);
            end
            step();
            step();
            step();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++;
            if (dout !== val || chg !== 1'b1 || chg_cnt !== exp_cnt[7:0]) begin
                errors++;
                $display("FAIL sat_accept[%0d]: dout=%b chg=%b chg_cnt=%0d, want %b/1/%0d",
                         i, dout, chg, chg_cnt, val, exp_cnt);
            end
        end
        step();
        checks++;
        if (chg_cnt !== 8'hFF || chg !== 1'b0) begin
            errors++;
            $display("FAIL sat_final: chg_cnt=%h chg=%b, want FF/0", chg_cnt, chg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_accept();
        test_glitch();
        test_restart();
        test_reset_mid_settle();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
